// File: rtl/conv_complex_stream.sv
// Streaming complex FIR: full linear convolution of a NUM_ELEMS-sample frame
// with a KERNEL_LEN-tap complex kernel. Valid/ready in and out, one result
// register, round-to-nearest with saturation and a sticky overflow flag.

// One complex tap product at full precision (2W+1 bits, 2*QF fraction).
module conv_cmul #(
    parameter int W = 6
) (
    input  logic signed [W-1:0]   hr,
    input  logic signed [W-1:0]   hi,
    input  logic signed [W-1:0]   xr,
    input  logic signed [W-1:0]   xi,
    output logic signed [2*W:0]   pr,
    output logic signed [2*W:0]   pi
);
    logic signed [2*W-1:0] rr, ii, ri, ir;

    // Partial products, then the complex combine with one guard bit.
    always_comb begin
        rr = (2*W)'(hr) * (2*W)'(xr);
        ii = (2*W)'(hi) * (2*W)'(xi);
        ri = (2*W)'(hr) * (2*W)'(xi);
        ir = (2*W)'(hi) * (2*W)'(xr);
        pr = (2*W+1)'(rr) - (2*W+1)'(ii);
        pi = (2*W+1)'(ri) + (2*W+1)'(ir);
    end
endmodule

module conv_complex_stream #(
    parameter int QI         = 3,
    parameter int QF         = 3,
    parameter int KERNEL_LEN = 3,
    parameter int NUM_ELEMS  = 100
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [2*(QI+QF)*KERNEL_LEN-1:0]      kernel,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [2*(QI+QF)-1:0]                 in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [2*(QI+QF)-1:0]                 out_data,
    output logic                                 overflow,
    output logic                                 busy,
    output logic                                 done
);
    localparam int W   = QI + QF;
    localparam int PW  = 2*W + 1;
    localparam int AW  = PW + $clog2(KERNEL_LEN);
    localparam int ICW = $clog2(NUM_ELEMS + 1);
    localparam int OCW = $clog2(NUM_ELEMS + KERNEL_LEN);
    localparam int ZCW = $clog2(KERNEL_LEN);

    localparam logic signed [AW:0] RND  = (AW+1)'((QF > 0) ? (1 << (QF-1)) : 0);
    localparam logic signed [AW:0] SMAX = (AW+1)'((1 << (W-1)) - 1);
    localparam logic signed [AW:0] SMIN = (AW+1)'(-(1 << (W-1)));

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                      state, state_n;
    cplx_t [KERNEL_LEN-1:0]      h_q;
    cplx_t [KERNEL_LEN-2:0]      dly;
    cplx_t [KERNEL_LEN-1:0]      win;
    cplx_t                       x_new;
    cplx_t                       res;
    logic [ICW-1:0]              in_cnt;
    logic [OCW-1:0]              out_cnt;
    logic [ZCW-1:0]              zcnt;
    logic signed [PW-1:0]        pr [KERNEL_LEN];
    logic signed [PW-1:0]        pi [KERNEL_LEN];
    logic signed [AW-1:0]        acc_re, acc_im;
    logic [W:0]                  sr, si;
    logic                        stage_free, in_fire, out_fire, adv;

    // Round half up, shift out QF fraction bits, clamp to W bits; MSB flags a clamp.
    function automatic logic [W:0] round_sat(input logic signed [AW-1:0] acc);
        logic signed [AW:0] rnd;
        logic signed [AW:0] sh;
        rnd = (AW+1)'(acc) + RND;
        sh  = rnd >>> QF;
        if (sh > SMAX)
            return {1'b1, SMAX[W-1:0]};
        else if (sh < SMIN)
            return {1'b1, SMIN[W-1:0]};
        else
            return {1'b0, sh[W-1:0]};
    endfunction

    assign stage_free = !out_valid || out_ready;
    assign in_ready   = (state == S_RUN) && stage_free;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    // FLUSH pushes KERNEL_LEN-1 zeros through the window, one per free stage slot.
    assign adv        = in_fire ||
                        ((state == S_FLUSH) && stage_free && (zcnt != ZCW'(KERNEL_LEN-1)));

    // Sample entering tap 0 this cycle: live input in RUN, zero during FLUSH.
    always_comb begin
        x_new = '0;
        if (state == S_RUN)
            x_new = cplx_t'(in_data);
    end

    // Tap window: new sample at tap 0, stored history behind it.
    always_comb begin
        win    = '0;
        win[0] = x_new;
        for (int k = 1; k < KERNEL_LEN; k++)
            win[k] = dly[k-1];
    end

    genvar gk;
    for (gk = 0; gk < KERNEL_LEN; gk++) begin : g_tap
        conv_cmul #(.W(W)) u_mul (
            .hr (h_q[gk].re),
            .hi (h_q[gk].im),
            .xr (win[gk].re),
            .xi (win[gk].im),
            .pr (pr[gk]),
            .pi (pi[gk])
        );
    end

    // Sum all tap products with enough headroom that the sum cannot wrap.
    always_comb begin
        acc_re = '0;
        acc_im = '0;
        for (int k = 0; k < KERNEL_LEN; k++) begin
            acc_re = acc_re + AW'(pr[k]);
            acc_im = acc_im + AW'(pi[k]);
        end
    end

    // Rounded, saturated result for the output register.
    always_comb begin
        sr     = round_sat(acc_re);
        si     = round_sat(acc_im);
        res    = '0;
        res.re = sr[W-1:0];
        res.im = si[W-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Next state: frame ends only on terminal input and output counts.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_RUN;
            S_RUN:   if (in_fire && in_cnt == ICW'(NUM_ELEMS-1)) state_n = S_FLUSH;
            S_FLUSH: if (out_fire && out_cnt == OCW'(NUM_ELEMS+KERNEL_LEN-2)) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Kernel latch, delay line, counters and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q      <= '0;
            dly      <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            zcnt     <= '0;
            overflow <= 1'b0;
        end else if (state == S_IDLE && start) begin
            h_q      <= kernel;
            dly      <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            zcnt     <= '0;
            overflow <= 1'b0;
        end else begin
            if (adv) begin
                dly[0] <= x_new;
                for (int k = 1; k < KERNEL_LEN-1; k++)
                    dly[k] <= dly[k-1];
            end
            if (in_fire)
                in_cnt <= in_cnt + ICW'(1);
            if (adv && state == S_FLUSH)
                zcnt <= zcnt + ZCW'(1);
            if (out_fire)
                out_cnt <= out_cnt + OCW'(1);
            if (adv && (sr[W] || si[W]))
                overflow <= 1'b1;
        end
    end

    // Single output stage: load on advance, otherwise drain when accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= 1'b1;
            out_data  <= res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Status flags registered off the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_n == S_RUN) || (state_n == S_FLUSH);
            done <= (state_n == S_DONE);
        end
    end
endmodule
